// File: rtl/replace_num_ctrl_if.sv
// Bundles the controller's UART request, sample stream and replacement-memory
// signals. The master view belongs to the controller; the slave view is the environment.
interface replace_num_ctrl_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16
);
  logic                             enable;
  logic                             wr_req_valid;
  logic                             wr_req_ready;
  logic [ADDR_WIDTH+DATA_WIDTH-1:0] wr_req_packet;
  logic                             s_valid;
  logic                             s_first;
  logic [DATA_WIDTH-1:0]            s_data;
  logic                             s_ready;
  logic                             m_valid;
  logic [DATA_WIDTH-1:0]            m_data;
  logic                             m_replaced;
  logic [15:0]                      replace_count;
  logic [ADDR_WIDTH+DATA_WIDTH-1:0] mem_wr_packet;
  logic                             mem_wr_en;
  logic [ADDR_WIDTH-1:0]            mem_rd_addr;
  logic                             mem_rd_en;
  logic [DATA_WIDTH-1:0]            mem_data_in;
  logic                             mem_valid_in;

  modport master (
    input  enable, wr_req_valid, wr_req_packet, s_valid, s_first, s_data,
           mem_data_in, mem_valid_in,
    output wr_req_ready, s_ready, m_valid, m_data, m_replaced, replace_count,
           mem_wr_packet, mem_wr_en, mem_rd_addr, mem_rd_en
  );

  modport slave (
    output enable, wr_req_valid, wr_req_packet, s_valid, s_first, s_data,
           mem_data_in, mem_valid_in,
    input  wr_req_ready, s_ready, m_valid, m_data, m_replaced, replace_count,
           mem_wr_packet, mem_wr_en, mem_rd_addr, mem_rd_en
  );
endinterface

// File: rtl/replace_num_ctrl.sv
// Replacement-number sequencer: per-sample memory lookups with substitution, plus
// UART writes scheduled only into slots that do not collide with the memory's post-read clear.
module replace_num_ctrl #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16,
  parameter int MAX_WAIT   = 8
) (
  input logic                clk,
  input logic                rst,
  replace_num_ctrl_if.master bus
);
  localparam int PKT_WIDTH  = ADDR_WIDTH + DATA_WIDTH;
  localparam int WAIT_WIDTH = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_WIDTH-1:0] WAIT_LAST = WAIT_WIDTH'(MAX_WAIT - 2);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    STALL   = 2'd2
  } state_t;

  state_t                  state_reg, state_next;
  logic [PKT_WIDTH-1:0]    pkt_reg, pkt_next;
  logic [WAIT_WIDTH-1:0]   wait_reg, wait_next;
  logic                    rd_prev_reg;
  logic                    wr_fire;
  logic                    req_open;
  logic                    stream_open;

  logic [ADDR_WIDTH-1:0]   idx_reg;
  logic [ADDR_WIDTH-1:0]   idx_eff;
  logic                    accept;
  logic                    rd_fire;

  logic                    st_valid_reg;
  logic                    st_enable_reg;
  logic [DATA_WIDTH-1:0]   st_data_reg;
  logic                    hit;

  logic                    m_valid_reg;
  logic                    m_replaced_reg;
  logic [DATA_WIDTH-1:0]   m_data_reg;
  logic [15:0]             count_reg;

  // ---------------- write scheduling FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      pkt_reg     <= '0;
      wait_reg    <= '0;
      rd_prev_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      pkt_reg     <= pkt_next;
      wait_reg    <= wait_next;
      rd_prev_reg <= rd_fire;
    end
  end

  // A write may only fire when no read happened last cycle, since that slot
  // belongs to the memory's clear of the entry just read.
  always_comb begin
    state_next  = state_reg;
    pkt_next    = pkt_reg;
    wait_next   = wait_reg;
    wr_fire     = 1'b0;
    req_open    = 1'b0;
    stream_open = 1'b1;
    case (state_reg)
      IDLE: begin
        req_open = 1'b1;
        if (bus.wr_req_valid) begin
          pkt_next   = bus.wr_req_packet;
          wait_next  = '0;
          state_next = PENDING;
        end
      end
      PENDING: begin
        if (!rd_prev_reg) begin
          wr_fire    = 1'b1;
          state_next = IDLE;
        end else begin
          wait_next = wait_reg + WAIT_WIDTH'(1);
          if (wait_reg == WAIT_LAST) begin
            state_next = STALL;
          end
        end
      end
      STALL: begin
        // Blocking the stream for one cycle guarantees a read-free slot next cycle.
        stream_open = 1'b0;
        state_next  = PENDING;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---------------- index and lookup ----------------
  assign accept  = bus.s_valid && stream_open && !rst;
  assign idx_eff = bus.s_first ? '0 : idx_reg;
  assign rd_fire = accept && bus.enable;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_reg <= '0;
    end else if (accept) begin
      idx_reg <= idx_eff + ADDR_WIDTH'(1);
    end
  end

  // ---------------- stage 1 and output stage ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_valid_reg  <= 1'b0;
      st_enable_reg <= 1'b0;
      st_data_reg   <= '0;
    end else begin
      st_valid_reg  <= accept;
      st_enable_reg <= bus.enable;
      st_data_reg   <= bus.s_data;
    end
  end

  assign hit = st_valid_reg && st_enable_reg && bus.mem_valid_in;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid_reg    <= 1'b0;
      m_replaced_reg <= 1'b0;
      m_data_reg     <= '0;
      count_reg      <= '0;
    end else begin
      m_valid_reg <= st_valid_reg;
      if (hit) begin
        m_data_reg     <= bus.mem_data_in;
        m_replaced_reg <= 1'b1;
        if (count_reg != 16'hFFFF) begin
          count_reg <= count_reg + 16'd1;
        end
      end else begin
        m_data_reg     <= st_data_reg;
        m_replaced_reg <= 1'b0;
      end
    end
  end

  // ---------------- outputs ----------------
  assign bus.wr_req_ready  = req_open && !rst;
  assign bus.s_ready       = stream_open && !rst;
  assign bus.m_valid       = m_valid_reg;
  assign bus.m_data        = m_data_reg;
  assign bus.m_replaced    = m_replaced_reg;
  assign bus.replace_count = count_reg;
  assign bus.mem_wr_packet = pkt_reg;
  assign bus.mem_wr_en     = wr_fire;
  assign bus.mem_rd_addr   = idx_eff;
  assign bus.mem_rd_en     = rd_fire;
endmodule
